// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size codes and MEM-stage FSM states.
package mips_pkg;

   localparam logic [2:0] SIZE_BYTE = 3'b001;
   localparam logic [2:0] SIZE_HALF = 3'b010;
   localparam logic [2:0] SIZE_WORD = 3'b100;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: one synchronous byte-enabled write port,
// two asynchronous read ports (pipeline access and debug).
module data_memory #(
   parameter int NB      = 32,
   parameter int DEPTH   = 256,
   parameter int NB_ADDR = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [NB_ADDR-1:0] waddr,
   input  logic [3:0]         wbe,
   input  logic [NB-1:0]      wdata,
   input  logic [NB_ADDR-1:0] raddr,
   output logic [NB-1:0]      rdata,
   input  logic [NB_ADDR-1:0] daddr,
   output logic [NB-1:0]      ddata
);

   logic [NB-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[raddr];
   assign ddata = mem[daddr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: clear-sweep FSM, byte/half/word store lanes, load extension.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
   import mips_pkg::*;
#(
   parameter int NB           = 32,
   parameter int NB_SIZE_TYPE = 3,
   parameter int DEPTH        = 256,
   parameter int NB_ADDR      = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_step,
   input  logic [NB-1:0]           i_alu_result,
   input  logic [NB-1:0]           i_data_b_to_write,
   input  logic                    i_mem_read,
   input  logic                    i_mem_write,
   input  logic [NB_SIZE_TYPE-1:0] i_word_size,
   input  logic                    i_signed,
   input  logic                    i_branch,
   input  logic                    i_cero,
   input  logic [NB_ADDR-1:0]      i_debug_addr,
   output logic [NB-1:0]           o_read_data,
   output logic [NB-1:0]           o_debug_data,
   output logic                    o_branch_taken,
   output logic                    o_ready,
   output logic                    o_misaligned
);

   mem_state_t         state;
   logic [NB_ADDR-1:0] cnt;
   logic [NB_ADDR-1:0] idx;
   logic [1:0]         lane;
   logic               run;
   logic               mis;
   logic [3:0]         be;
   logic [NB-1:0]      st_data;
   logic               we;
   logic [NB_ADDR-1:0] waddr;
   logic [3:0]         wbe;
   logic [NB-1:0]      wdata;
   logic [NB-1:0]      rword;
   logic [NB-1:0]      dword;
   logic [NB-1:0]      ld_data;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic               is_byte;
   logic               is_half;
   logic               is_word;
   logic               unused_addr;

   assign idx         = i_alu_result[NB_ADDR+1:2];
   assign lane        = i_alu_result[1:0];
   assign unused_addr = ^i_alu_result[NB-1:NB_ADDR+2];
   assign run         = (state == ST_RUN);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else if (state == ST_CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == NB_ADDR'(DEPTH - 1)) state <= ST_RUN;
      end
   end

   assign o_ready        = run;
   assign o_branch_taken = i_branch & i_cero;

   // Unknown size codes fall through to full-word access
   assign is_byte = (i_word_size == NB_SIZE_TYPE'(SIZE_BYTE));
   assign is_half = (i_word_size == NB_SIZE_TYPE'(SIZE_HALF));
   assign is_word = !is_byte && !is_half;

`ifdef MEM_ALIGN_CHECK_EN
   assign mis = (i_mem_read | i_mem_write) &
                ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   assign o_misaligned = mis;

   always_comb begin
      be      = 4'b1111;
      st_data = i_data_b_to_write;
      if (is_byte) begin
         be      = 4'b0001 << lane;
         st_data = {4{i_data_b_to_write[7:0]}};
      end else if (is_half) begin
         be      = lane[1] ? 4'b1100 : 4'b0011;
         st_data = {2{i_data_b_to_write[15:0]}};
      end
   end

   // The sweep owns the write port until the whole array is zeroed
   assign we    = !run || (i_step && i_mem_write && !mis);
   assign waddr = run ? idx : cnt;
   assign wbe   = run ? be : 4'b1111;
   assign wdata = run ? st_data : '0;

   data_memory #(
      .NB      (NB),
      .DEPTH   (DEPTH),
      .NB_ADDR (NB_ADDR)
   ) u_dmem (
      .clk   (i_clk),
      .we    (we),
      .waddr (waddr),
      .wbe   (wbe),
      .wdata (wdata),
      .raddr (idx),
      .rdata (rword),
      .daddr (i_debug_addr),
      .ddata (dword)
   );

   assign ld_byte = rword[8*lane +: 8];
   assign ld_half = lane[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      ld_data = rword;
      if (is_byte) begin
         ld_data = {{(NB-8){i_signed & ld_byte[7]}}, ld_byte};
      end else if (is_half) begin
         ld_data = {{(NB-16){i_signed & ld_half[15]}}, ld_half};
      end
   end

   assign o_read_data  = (run && i_mem_read && !mis) ? ld_data : '0;
   assign o_debug_data = run ? dword : '0;

endmodule
